div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU.
- The execute stage issues operands and a start strobe, then holds its stall request until ready_o.
- The 64-bit result {remainder, quotient} is consumed by the execute stage as {hi_o, lo_o} with whilo_o asserted.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits. Only 32 is required to be verified.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- signed_div_i  in  1  1 = DIV (two's-complement operands), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend; sampled only on the accepting edge.
- opdata2_i  in  WIDTH  divisor; sampled only on the accepting edge.
- start_i  in  1  request; held high by the execute stage until it has consumed ready_o.
- annul_i  in  1  abort (branch-delay/flush); cancels any operation in progress.
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = FREE, cnt = 0.
  - result_o = 0, ready_o = 0.
  - Internal dividend/divisor registers cleared.
  - Reset mid-operation discards the operation with no residue.
- FREE state:
  - start_i = 1 and annul_i = 0 at the edge:
    - If opdata2_i == 0, go to BYZERO.
    - Otherwise go to ON with cnt = 0.
    - Operands latched as absolute values when signed_div_i = 1 and the sign bit is 1 (~x + 1); otherwise latched raw.
    - Both original sign bits and signed_div_i are latched.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO state: next edge goes to END with quotient = 0 and remainder = 0. No exception is raised.
- ON state:
  - Working register is 65 bits: {partial remainder[64:32], dividend/quotient[31:0]}, loaded as {33'b0, |dividend|}.
  - Each edge with annul_i = 0:
    - Shift the working register left by 1.
    - Trial = upper 33 bits − {1'b0, |divisor|}.
    - If the trial is non-negative, the upper bits take the trial and bit 0 = 1; else bit 0 = 0.
    - cnt increments.
  - When cnt == 32 at an edge (33rd edge after acceptance), go to END instead of iterating. Apply signed fixups:
    - Quotient negated if signed and dividend sign ≠ divisor sign.
    - Remainder negated if signed and dividend sign = 1 (remainder takes the dividend's sign).
  - annul_i = 1 at any ON edge: go to FREE, cnt = 0, ready_o stays 0.
- END state:
  - ready_o = 1 and result_o holds the final value.
  - Stays in END while start_i = 1.
  - start_i = 0: next edge goes to FREE, ready_o = 0, result_o = 0.
  - annul_i is ignored in END and BYZERO.
- Latency:
  - Non-zero divisor: ready_o rises 33 edges after the accepting edge (counted as edge 0).
  - Zero divisor: ready_o rises 2 edges after the accepting edge.
- Edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Back-to-back operations need one FREE cycle between them, because start_i must drop first.
  - start_i and annul_i both high in FREE: the request is not accepted.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Unsigned, 100 / 7 -> ready_o at accept+33; result_o = {0x00000002, 0x0000000E}.
- Unsigned, 0xFFFFFFFF / 0x10 -> result_o = {0x0000000F, 0x0FFFFFFF}.
- Signed, -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed, 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed, 0x80000000 / -1 -> {0, 0x80000000}.
- Divide by zero, 5 / 0 -> ready_o at accept+2, result_o = 0.
- Abort and reset:
  - annul_i pulsed at iteration 10 -> FREE, ready_o never asserts.
  - A new 9 / 3 then yields {0, 3}.
  - rst = 0 asserted mid-ON -> outputs immediately 0, FREE.
- Handshake: hold start_i 5 cycles past ready_o -> result stable and ready_o held; drop start_i -> ready_o = 0 the next edge.

Source files
------------

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU.
// One quotient bit is resolved per clock. Operands are converted to magnitudes
// when they are accepted. The signs are re-applied once the last iteration is done.
// The final result is {remainder, quotient}.
module div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH:0]   work_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               sign1_r;
    logic               sign2_r;
    logic               signed_r;

    logic [WIDTH-1:0]   abs1_s;
    logic [WIDTH-1:0]   abs2_s;
    logic [2*WIDTH:0]   shifted_s;
    logic [WIDTH+1:0]   trial_s;
    logic [2*WIDTH:0]   next_work_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    // Two's-complement negation, shared by operand magnitude and result fixup
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        negate = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes, one shift-subtract step and signed result fixups
    always_comb begin
        if (signed_div_i && opdata1_i[WIDTH-1]) begin
            abs1_s = negate(opdata1_i);
        end else begin
            abs1_s = opdata1_i;
        end
        if (signed_div_i && opdata2_i[WIDTH-1]) begin
            abs2_s = negate(opdata2_i);
        end else begin
            abs2_s = opdata2_i;
        end

        shifted_s = {work_r[2*WIDTH-1:0], 1'b0};
        trial_s   = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, divisor_r};
        if (trial_s[WIDTH+1]) begin
            next_work_s = shifted_s;
        end else begin
            next_work_s = {trial_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
        end

        if (signed_r && (sign1_r != sign2_r)) begin
            quot_s = negate(work_r[WIDTH-1:0]);
        end else begin
            quot_s = work_r[WIDTH-1:0];
        end
        if (signed_r && sign1_r) begin
            rem_s = negate(work_r[2*WIDTH-1:WIDTH]);
        end else begin
            rem_s = work_r[2*WIDTH-1:WIDTH];
        end
    end

    // Divider control FSM with registered result and ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_FREE;
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {(2*WIDTH+1){1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            signed_r  <= 1'b0;
            result_o  <= {(2*WIDTH){1'b0}};
            ready_o   <= 1'b0;
        end else begin
            case (state_r)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= {(2*WIDTH){1'b0}};
                    if (start_i && !annul_i) begin
                        sign1_r   <= opdata1_i[WIDTH-1];
                        sign2_r   <= opdata2_i[WIDTH-1];
                        signed_r  <= signed_div_i;
                        divisor_r <= abs2_s;
                        work_r    <= {{(WIDTH+1){1'b0}}, abs1_s};
                        cnt_r     <= {CNT_W{1'b0}};
                        if (opdata2_i == {WIDTH{1'b0}}) begin
                            state_r <= ST_BYZERO;
                        end else begin
                            state_r <= ST_ON;
                        end
                    end else begin
                        state_r <= ST_FREE;
                    end
                end
                ST_BYZERO: begin
                    // Divide by zero yields all-zero result without a trap
                    result_o <= {(2*WIDTH){1'b0}};
                    state_r  <= ST_END;
                end
                ST_ON: begin
                    if (annul_i) begin
                        state_r <= ST_FREE;
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_o <= 1'b0;
                    end else if (cnt_r == CNT_W'(WIDTH)) begin
                        state_r  <= ST_END;
                        ready_o  <= 1'b1;
                        result_o <= {rem_s, quot_s};
                    end else begin
                        work_r <= next_work_s;
                        cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_END: begin
                    if (start_i) begin
                        ready_o <= 1'b1;
                    end else begin
                        state_r  <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= {(2*WIDTH){1'b0}};
                    end
                end
                default: begin
                    state_r  <= ST_FREE;
                    ready_o  <= 1'b0;
                    result_o <= {(2*WIDTH){1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed testbench for the multi-cycle divider.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors;
    int checks;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check result, hold, then release
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [63:0] exp_res, input int hold);
        int   lat;
        logic seen;
        logic [63:0] first;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Operands must only matter at the accepting edge
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (lat < 60 && !seen) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        first = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold ready"}, 64'(ready_o), 64'd1);
            check({tag, " hold result"}, result_o, first);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    // Watch a window of cycles and report whether ready ever rose
    task automatic watch_no_ready(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_div("u 100/7",      1'b0, 32'd100,      32'd7,        33, {32'h0000_0002, 32'h0000_000E}, 5);
        run_div("u ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10,      33, {32'h0000_000F, 32'h0FFF_FFFF}, 0);
        run_div("s -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,        33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("s 7/-2",       1'b1, 32'd7,        32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD}, 0);
        run_div("s min/-1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000}, 0);
        run_div("u min/max",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0000_0000}, 0);
        run_div("s -100/7",     1'b1, 32'hFFFF_FF9C, 32'd7,        33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0);
        run_div("div by zero",  1'b0, 32'd5,        32'd0,         2, 64'd0, 0);

        // Abort at iteration 10
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        watch_no_ready("annul no ready", 40);
        run_div("u 9/3 after annul", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3}, 0);

        // Start together with annul is not accepted
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        watch_no_ready("start+annul ignored", 40);

        // Reset mid-operation
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst mid-on ready", 64'(ready_o), 64'd0);
        check("rst mid-on result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        watch_no_ready("rst mid-on no ready", 40);
        run_div("u 9/3 after rst", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3}, 0);

        // Reset while a result is presented clears outputs asynchronously
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        check("pre-rst end ready", 64'(ready_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst in end ready", 64'(ready_o), 64'd0);
        check("rst in end result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
